// File: rtl/alu_cmd_driver.sv
// Command/response sequencer for the external 8-bit combinational ALU.
// Registers operands, captures result one cycle later, returns it on a handshake.
module alu_cmd_driver #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_opcode,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_chain,
    output logic [2:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             busy,
    output logic [CNT_W-1:0] op_count,
    output logic             zero_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] acc;
    logic             accept;
    logic             complete;

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        accept    = 1'b0;
        complete  = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                accept    = cmd_valid;
                if (cmd_valid) state_nxt = EXEC;
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                complete  = rsp_ready;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b1;
            acc        <= '0;
            op_count   <= '0;
            zero_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            // Operands only move on accept so the ALU inputs stay stable.
            if (accept) begin
                alu_opcode <= cmd_opcode;
                alu_b      <= cmd_b;
                alu_a      <= cmd_chain ? acc : cmd_a;
            end
            if (state == EXEC) begin
                rsp_result <= alu_result;
                rsp_zero   <= alu_zero;
                acc        <= alu_result;
                if (alu_zero != (alu_result == '0)) zero_err <= 1'b1;
            end
            if (complete) op_count <= op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed table-driven bench for alu_cmd_driver with a behavioural ALU model.
module tb_alu_cmd_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_opcode;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       cmd_chain;
    logic [2:0] alu_opcode;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_zero;
    logic       busy;
    logic [15:0] op_count;
    logic       zero_err;

    logic       cmd_ready_w;
    logic [2:0] alu_opcode_w;
    logic [7:0] alu_a_w;
    logic [7:0] alu_b_w;
    logic       rsp_valid_w;
    logic [7:0] rsp_result_w;
    logic       rsp_zero_w;
    logic       busy_w;
    logic [3:0] op_count_w;
    logic       zero_err_w;

    logic       force_zero;
    int         vectors = 0;
    int         miscompares = 0;
    int         exp_cnt = 0;

    always #5 clk = ~clk;

    alu_cmd_driver #(.WIDTH(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .cmd_chain(cmd_chain),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .busy(busy), .op_count(op_count), .zero_err(zero_err)
    );

    // Narrow counter copy runs in lockstep to reach the wrap point quickly.
    alu_cmd_driver #(.WIDTH(8), .CNT_W(4)) u_dut_w (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_w),
        .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .cmd_chain(cmd_chain),
        .alu_opcode(alu_opcode_w), .alu_a(alu_a_w), .alu_b(alu_b_w),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid_w), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result_w), .rsp_zero(rsp_zero_w),
        .busy(busy_w), .op_count(op_count_w), .zero_err(zero_err_w)
    );

    always_comb begin
        alu_result = 8'h00;
        case (alu_opcode)
            3'b000: alu_result = alu_a + alu_b;
            3'b001: alu_result = alu_a - alu_b;
            3'b010: alu_result = alu_a & alu_b;
            3'b011: alu_result = alu_a | alu_b;
            3'b100: alu_result = alu_a ^ alu_b;
            3'b101: alu_result = ~alu_a;
            3'b110: alu_result = alu_a >> 1;
            default: alu_result = alu_a << 1;
        endcase
        alu_zero = force_zero | (alu_result == 8'h00);
    end

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       chain;
        logic [7:0] exp_a;
        logic [7:0] exp_res;
        logic       exp_zero;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 20) chk({name, "_idle_timeout"}, 0, 1);
    endtask

    // Accept, then check EXEC cycle and RESP contents; leaves DUT in RESP.
    task automatic issue(input vec_t v, input string name);
        wait_idle(name);
        @(negedge clk);
        cmd_opcode = v.op;
        cmd_a      = v.a;
        cmd_b      = v.b;
        cmd_chain  = v.chain;
        cmd_valid  = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk({name, "_alu_a"}, alu_a, v.exp_a);
        chk({name, "_alu_op"}, alu_opcode, v.op);
        chk({name, "_exec_rsp_valid"}, rsp_valid, 0);
        @(posedge clk);
        #1;
        chk({name, "_rsp_valid"}, rsp_valid, 1);
        chk({name, "_rsp_result"}, rsp_result, v.exp_res);
        chk({name, "_rsp_zero"}, rsp_zero, v.exp_zero);
        chk({name, "_cmd_ready_resp"}, cmd_ready, 0);
    endtask

    task automatic consume(input string name);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        exp_cnt++;
        chk({name, "_done_valid"}, rsp_valid, 0);
        chk({name, "_done_ready"}, cmd_ready, 1);
        chk({name, "_op_count"}, op_count, exp_cnt & 32'hFFFF);
    endtask

    vec_t v;
    logic [7:0] held;

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_opcode = 3'b000;
        cmd_a      = 8'h00;
        cmd_b      = 8'h00;
        cmd_chain  = 1'b0;
        rsp_ready  = 1'b0;
        force_zero = 1'b0;

        tbl[0]  = '{3'b000, 8'h0F, 8'h01, 1'b0, 8'h0F, 8'h10, 1'b0};
        tbl[1]  = '{3'b001, 8'h05, 8'h05, 1'b0, 8'h05, 8'h00, 1'b1};
        tbl[2]  = '{3'b000, 8'hFF, 8'h01, 1'b0, 8'hFF, 8'h00, 1'b1};
        tbl[3]  = '{3'b010, 8'hF0, 8'h3C, 1'b0, 8'hF0, 8'h30, 1'b0};
        tbl[4]  = '{3'b011, 8'hF0, 8'h0F, 1'b0, 8'hF0, 8'hFF, 1'b0};
        tbl[5]  = '{3'b100, 8'hAA, 8'hFF, 1'b0, 8'hAA, 8'h55, 1'b0};
        tbl[6]  = '{3'b101, 8'h5A, 8'h00, 1'b0, 8'h5A, 8'hA5, 1'b0};
        tbl[7]  = '{3'b110, 8'h81, 8'h00, 1'b0, 8'h81, 8'h40, 1'b0};
        tbl[8]  = '{3'b000, 8'h03, 8'h04, 1'b0, 8'h03, 8'h07, 1'b0};
        tbl[9]  = '{3'b111, 8'hC3, 8'h99, 1'b1, 8'h07, 8'h0E, 1'b0};
        tbl[10] = '{3'b001, 8'h77, 8'h0E, 1'b1, 8'h0E, 8'h00, 1'b1};

        do_reset();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_zero", rsp_zero, 1);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_busy", busy, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_zero_err", zero_err, 0);

        for (int i = 0; i < 11; i++) begin
            issue(tbl[i], $sformatf("vec%0d", i));
            consume($sformatf("vec%0d", i));
        end

        // Backpressure: response held for 5 cycles
        v = '{3'b000, 8'h20, 8'h22, 1'b0, 8'h20, 8'h42, 1'b0};
        issue(v, "hold");
        held = rsp_result;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", rsp_valid, 1);
            chk("hold_result", rsp_result, held);
            chk("hold_cmd_ready", cmd_ready, 0);
            chk("hold_op_count", op_count, exp_cnt);
        end
        // Command waiting while response completes must not be taken that edge
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_opcode = 3'b000;
        cmd_a      = 8'h11;
        cmd_b      = 8'h11;
        cmd_chain  = 1'b0;
        rsp_ready  = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        exp_cnt++;
        chk("hold_release_count", op_count, exp_cnt);
        chk("hold_release_busy", busy, 0);
        chk("hold_release_ready", cmd_ready, 1);
        chk("hold_release_alu_a", alu_a, 8'h20);

        // Reset during EXEC
        wait_idle("rst_exec");
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_opcode = 3'b011;
        cmd_a      = 8'h0C;
        cmd_b      = 8'h30;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("rst_exec_busy_pre", busy, 1);
        do_reset();
        chk("rst_exec_busy", busy, 0);
        chk("rst_exec_valid", rsp_valid, 0);
        chk("rst_exec_alu_a", alu_a, 0);
        chk("rst_exec_alu_b", alu_b, 0);
        chk("rst_exec_result", rsp_result, 0);
        chk("rst_exec_zero", rsp_zero, 1);
        chk("rst_exec_count", op_count, 0);

        // Chain straight after reset uses a cleared accumulator
        v = '{3'b000, 8'h55, 8'h21, 1'b1, 8'h00, 8'h21, 1'b0};
        issue(v, "chain_rst");
        // Reset during RESP: response discarded, count not stepped
        do_reset();
        chk("rst_resp_valid", rsp_valid, 0);
        chk("rst_resp_ready", cmd_ready, 1);
        chk("rst_resp_count", op_count, 0);
        chk("rst_resp_result", rsp_result, 0);
        chk("rst_resp_alu_op", alu_opcode, 0);

        // Inconsistent zero flag is sticky
        force_zero = 1'b1;
        v = '{3'b000, 8'h01, 8'h00, 1'b0, 8'h01, 8'h01, 1'b1};
        issue(v, "zerr");
        force_zero = 1'b0;
        chk("zerr_set", zero_err, 1);
        consume("zerr");
        v = '{3'b100, 8'h3C, 8'h0F, 1'b0, 8'h3C, 8'h33, 1'b0};
        issue(v, "zerr_keep");
        consume("zerr_keep");
        chk("zerr_sticky", zero_err, 1);
        do_reset();
        chk("zerr_cleared", zero_err, 0);

        // Counter wrap on the 4-bit instance
        for (int i = 0; i < 15; i++) begin
            v = '{3'b000, 8'(i), 8'h01, 1'b0, 8'(i), 8'(i + 1), 1'b0};
            issue(v, $sformatf("wrap%0d", i));
            consume($sformatf("wrap%0d", i));
        end
        chk("wrap_pre", op_count_w, 15);
        v = '{3'b010, 8'hFF, 8'h00, 1'b0, 8'hFF, 8'h00, 1'b1};
        issue(v, "wrap_last");
        consume("wrap_last");
        chk("wrap_zero", op_count_w, 0);
        chk("wrap_wide", op_count, 16);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
